sfa_out_switch_n: RTL and testbench

SFA_OUT_SWITCH_N -- requirements
Module: sfa_out_switch_n

---
 rtl/sfa_out_switch_n.sv | 95 +++++++++
 tb/tb_sfa_out_switch_n.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sfa_out_switch_n.sv
// sfa_out_switch_n: one-to-N AXI-Stream switch with packet-latched routing, broadcast and a 2-entry skid FIFO.
module sfa_out_switch_n #(
    parameter int DATA_W  = 32,
    parameter int N_PORTS = 4,
    parameter int SEL_W   = 2
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [SEL_W-1:0]          CONF,
    input  logic                      CONF_BCAST,
    input  logic                      si_tvalid,
    output logic                      si_tready,
    input  logic [DATA_W-1:0]         si_tdata,
    input  logic                      si_tlast,
    output logic [N_PORTS-1:0]        m_tvalid,
    input  logic [N_PORTS-1:0]        m_tready,
    output logic [N_PORTS*DATA_W-1:0] m_tdata,
    output logic [N_PORTS-1:0]        m_tlast,
    output logic                      busy,
    output logic                      drop
);
    logic [DATA_W-1:0]  fifo_data [2];
    logic [SEL_W-1:0]   fifo_sel [2];
    logic [1:0]         fifo_last, fifo_bcast;
    logic               wr_ptr, rd_ptr;
    logic [1:0]         count, count_nxt;
    logic               pkt_open, pkt_bcast;
    logic [SEL_W-1:0]   pkt_sel;
    logic [N_PORTS-1:0] done_mask, taken;
    logic               accept, pop, head_valid, head_bcast, head_last, tag_bcast;
    logic [SEL_W-1:0]   head_sel, tag_sel;
    logic [DATA_W-1:0]  head_data;

    assign accept     = si_tvalid && si_tready;
    assign head_valid = count != 2'd0;
    assign head_data  = fifo_data[rd_ptr];
    assign head_sel   = fifo_sel[rd_ptr];
    assign head_last  = fifo_last[rd_ptr];
    assign head_bcast = fifo_bcast[rd_ptr];
    assign tag_bcast  = pkt_open ? pkt_bcast : CONF_BCAST;
    assign tag_sel    = pkt_open ? pkt_sel : CONF;

    always_comb begin
        m_tvalid = '0;
        m_tdata  = '0;
        m_tlast  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (head_valid && (head_bcast ? !done_mask[k] : head_sel == SEL_W'(k))) begin
                m_tvalid[k]                  = 1'b1;
                m_tdata[k*DATA_W +: DATA_W]  = head_data;
                m_tlast[k]                   = head_last;
            end
        end
    end

    // a unicast head that lights no port has an out-of-range destination
    assign taken     = m_tvalid & m_tready;
    assign drop      = head_valid && !head_bcast && m_tvalid == '0;
    assign pop       = head_valid && (head_bcast ? &(done_mask | taken) : (drop || taken != '0));
    assign count_nxt = count + 2'(accept) - 2'(pop);
    assign busy      = pkt_open || head_valid;

    always_ff @(posedge ACLK) begin
        if (accept) begin
            fifo_data[wr_ptr]  <= si_tdata;
            fifo_last[wr_ptr]  <= si_tlast;
            fifo_bcast[wr_ptr] <= tag_bcast;
            fifo_sel[wr_ptr]   <= tag_sel;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            si_tready <= 1'b0;
            done_mask <= '0;
            pkt_open  <= 1'b0;
            pkt_bcast <= 1'b0;
            pkt_sel   <= '0;
        end else begin
            wr_ptr    <= wr_ptr ^ accept;
            rd_ptr    <= rd_ptr ^ pop;
            count     <= count_nxt;
            si_tready <= count_nxt < 2'd2;
            done_mask <= pop ? '0 : (head_valid && head_bcast) ? done_mask | taken : done_mask;
            pkt_open  <= accept ? !si_tlast : pkt_open;
            if (accept && !pkt_open) begin
                pkt_bcast <= CONF_BCAST;
                pkt_sel   <= CONF;
            end
        end
    end
endmodule

// File: tb/tb_sfa_out_switch_n.sv
// tb_sfa_out_switch_n: directed scoreboard bench; per-port expected queues drained by a negedge monitor.
module tb_sfa_out_switch_n;
    localparam int DW = 32;
    localparam int NP = 4;

    logic ACLK = 0;
    logic ARESETN = 0;
    always #5 ACLK = ~ACLK;

    logic [1:0]       conf = 0;
    logic             conf_bcast = 0;
    logic             si_tvalid = 0, si_tlast = 0, si_tready;
    logic [DW-1:0]    si_tdata = 0;
    logic [NP-1:0]    m_tvalid, m_tlast;
    logic [NP-1:0]    m_tready = '1;
    logic [NP*DW-1:0] m_tdata;
    logic             busy, drop;

    logic [1:0]       b_conf = 0;
    logic             b_valid = 0, b_last = 0, b_ready, b_busy, b_drop;
    logic [DW-1:0]    b_data = 0;
    logic [2:0]       b_m_tvalid, b_m_tlast;
    logic [2:0]       b_m_tready = '1;
    logic [3*DW-1:0]  b_m_tdata;

    sfa_out_switch_n #(.DATA_W(DW), .N_PORTS(NP), .SEL_W(2)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .CONF(conf), .CONF_BCAST(conf_bcast),
        .si_tvalid(si_tvalid), .si_tready(si_tready), .si_tdata(si_tdata), .si_tlast(si_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .busy(busy), .drop(drop)
    );

    sfa_out_switch_n #(.DATA_W(DW), .N_PORTS(3), .SEL_W(2)) dut_b (
        .ACLK(ACLK), .ARESETN(ARESETN), .CONF(b_conf), .CONF_BCAST(1'b0),
        .si_tvalid(b_valid), .si_tready(b_ready), .si_tdata(b_data), .si_tlast(b_last),
        .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tdata(b_m_tdata), .m_tlast(b_m_tlast),
        .busy(b_busy), .drop(b_drop)
    );

    logic [DW:0] exp_q [NP][$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // exp_port < 0 means broadcast to every port; >= NP means no delivery
    task automatic send(input logic [DW-1:0] data, input logic last, input logic [1:0] c,
                        input logic bc, input int exp_port);
        int t = 0;
        conf = c; conf_bcast = bc; si_tdata = data; si_tlast = last; si_tvalid = 1;
        while (!si_tready && t < 200) begin
            @(posedge ACLK); #1; t++;
        end
        if (t >= 200) begin
            tests++; fails++;
            $display("FAIL send_timeout: si_tready stayed 0 for data %h, expected 1", data);
            si_tvalid = 0;
            return;
        end
        for (int k = 0; k < NP; k++)
            if (exp_port < 0 || exp_port == k) exp_q[k].push_back({last, data});
        @(posedge ACLK); #1;
        si_tvalid = 0;
    endtask

    logic [NP-1:0] prev_stall = '0;
    logic [DW:0]   prev_beat [NP];

    always @(negedge ACLK) begin : monitor
        logic [DW:0] beat;
        if (!ARESETN) prev_stall = '0;
        else for (int k = 0; k < NP; k++) begin
            beat = {m_tlast[k], m_tdata[k*DW +: DW]};
            if (prev_stall[k]) chk($sformatf("stable_p%0d", k), {m_tvalid[k], beat}, {1'b1, prev_beat[k]});
            if (!m_tvalid[k]) chk($sformatf("idle_zero_p%0d", k), beat, 0);
            else if (m_tready[k]) begin
                if (exp_q[k].size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_beat_p%0d: got %h, expected no beat", k, beat);
                end else chk($sformatf("beat_p%0d", k), beat, exp_q[k].pop_front());
            end
            prev_stall[k] = m_tvalid[k] && !m_tready[k];
            prev_beat[k]  = beat;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_tready", si_tready, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata != 0, 0);
        chk("rst_busy_drop", {busy, drop}, 0);
        chk("rst_b_tready", b_ready, 0);
        @(posedge ACLK); #1;
        ARESETN = 1;
        chk("rel_tready_low", si_tready, 0);
        @(posedge ACLK); #1;
        chk("rel_tready_high", si_tready, 1);

        // unicast to port 2 with one-cycle latency
        send(32'hA0, 0, 2, 0, 2);
        chk("lat_valid", m_tvalid, 4'b0100);
        chk("lat_data", m_tdata[2*DW +: DW], 32'hA0);
        send(32'hA1, 0, 2, 0, 2);
        send(32'hA2, 1, 2, 0, 2);
        chk("uni_tlast", {m_tvalid, m_tlast}, {4'b0100, 4'b0100});
        @(posedge ACLK); #1;
        chk("uni_drain", {busy, m_tvalid}, 0);

        // CONF changes mid-packet must not redirect it
        send(32'hB0, 0, 1, 0, 1);
        send(32'hB1, 0, 3, 0, 1);
        send(32'hB2, 0, 3, 0, 1);
        send(32'hB3, 1, 3, 0, 1);
        send(32'hB4, 1, 3, 0, 3);
        chk("next_pkt_port3", m_tvalid, 4'b1000);
        repeat (2) @(posedge ACLK); #1;
        chk("conf_drain", busy, 0);

        // backpressure on port 0
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'h10 + i, i == 5, 0, 0, 0);
            end
            begin
                m_tready = 4'b1110;
                repeat (5) @(posedge ACLK); #1;
                chk("bp_tready_low", si_tready, 0);
                chk("bp_busy", busy, 1);
                chk("bp_hold", m_tvalid, 4'b0001);
                m_tready = '1;
            end
        join
        repeat (3) @(posedge ACLK); #1;
        chk("bp_drain", busy, 0);

        // broadcast with staggered readiness
        m_tready = '0;
        send(32'h55, 1, 0, 1, -1);
        chk("bc_all", m_tvalid, 4'b1111);
        m_tready = 4'b0001;
        @(posedge ACLK); #1;
        chk("bc_step1", m_tvalid, 4'b1110);
        m_tready = 4'b0110;
        @(posedge ACLK); #1;
        chk("bc_step2", {busy, m_tvalid}, {1'b1, 4'b1000});
        m_tready = 4'b1000;
        @(posedge ACLK); #1;
        chk("bc_pop", {busy, m_tvalid}, 0);
        m_tready = '1;

        // invalid destination on a 3-port instance, then a valid one
        chk("inv_ready", b_ready, 1);
        b_conf = 3; b_data = 32'h77; b_last = 1; b_valid = 1;
        @(posedge ACLK); #1;
        b_valid = 0;
        chk("inv_drop", {b_drop, b_m_tvalid, b_busy}, {1'b1, 3'b000, 1'b1});
        @(posedge ACLK); #1;
        chk("inv_done", {b_drop, b_busy}, 0);
        b_conf = 2; b_data = 32'h78; b_valid = 1;
        @(posedge ACLK); #1;
        b_valid = 0;
        chk("b_valid_sel", {b_drop, b_m_tvalid, b_m_tdata[2*DW +: DW]}, {1'b0, 3'b100, 32'h78});
        @(posedge ACLK); #1;

        // reset in the middle of a packet
        m_tready = 4'b1110;
        send(32'hC0, 0, 0, 0, 0);
        conf = 0; si_tdata = 32'hC1; si_tlast = 0; si_tvalid = 1;
        ARESETN = 0;
        #1;
        chk("mid_rst_out", {m_tvalid, m_tlast, si_tready, busy, drop}, 0);
        chk("mid_rst_data", m_tdata != 0, 0);
        si_tvalid = 0;
        for (int k = 0; k < NP; k++) exp_q[k].delete();
        @(posedge ACLK); #1;
        ARESETN = 1;
        m_tready = '1;
        @(posedge ACLK); #1;
        chk("post_rst_ready", si_tready, 1);
        send(32'hD0, 1, 2, 0, 2);
        chk("post_rst_route", m_tvalid, 4'b0100);
        repeat (3) @(posedge ACLK); #1;
        chk("final_idle", busy, 0);
        for (int k = 0; k < NP; k++) chk($sformatf("q_empty_p%0d", k), exp_q[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
